// File: rtl/cpu_interlock_pkg.sv
// rtl/cpu_interlock_pkg.sv - shared types and helpers for the mox125 hazard/sequencing controller
package cpu_interlock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MULTI = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    localparam int NUM_REGS  = 16;
    localparam int REG_IDX_W = 4;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One-hot register mask, empty when the port is not enabled.
    function automatic logic [NUM_REGS-1:0] idx_mask(input logic en, input logic [REG_IDX_W-1:0] idx);
        logic [NUM_REGS-1:0] m;
        m = '0;
        if (en) begin
            m[idx] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/cpu_scoreboard.sv
// rtl/cpu_scoreboard.sv - 16-entry pending-write scoreboard with four hazard lookup ports
// Optional writeback bypass of the lookup under MOX125_WB_BYPASS_EN.
module cpu_scoreboard
    import cpu_interlock_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 set_en_i,
    input  logic                 rdA_en_i,
    input  logic [REG_IDX_W-1:0] riA_i,
    input  logic                 rdB_en_i,
    input  logic [REG_IDX_W-1:0] riB_i,
    input  logic                 wr0_en_i,
    input  logic [REG_IDX_W-1:0] wr0_idx_i,
    input  logic                 wr1_en_i,
    input  logic [REG_IDX_W-1:0] wr1_idx_i,
    input  logic                 wb0_en_i,
    input  logic [REG_IDX_W-1:0] wb0_idx_i,
    input  logic                 wb1_en_i,
    input  logic [REG_IDX_W-1:0] wb1_idx_i,
    output logic                 haz_o,
    output logic [NUM_REGS-1:0]  pending_o,
    output logic [NUM_REGS-1:0]  pending_next_o
);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] clr_mask;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] look_vec;

    assign clr_mask = idx_mask(wb0_en_i, wb0_idx_i) | idx_mask(wb1_en_i, wb1_idx_i);
    assign set_mask = set_en_i ? (idx_mask(wr0_en_i, wr0_idx_i) | idx_mask(wr1_en_i, wr1_idx_i))
                               : '0;

    // Clear first, then set, so a same-cycle issue to a retiring register stays pending.
    assign pending_next_o = (pending_q & ~clr_mask) | set_mask;

`ifdef MOX125_WB_BYPASS_EN
    assign look_vec = pending_q & ~clr_mask;
`else
    assign look_vec = pending_q;
`endif

    assign haz_o = (rdA_en_i & look_vec[riA_i])
                 | (rdB_en_i & look_vec[riB_i])
                 | (wr0_en_i & look_vec[wr0_idx_i])
                 | (wr1_en_i & look_vec[wr1_idx_i]);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_next_o;
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/cpu_interlock.sv
// rtl/cpu_interlock.sv - mox125 decode stall/flush controller (scoreboard, multi-cycle hold, flush sequencer)
// Writeback bypass of hazard lookup selected by MOX125_WB_BYPASS_EN.
module cpu_interlock
    import cpu_interlock_pkg::*;
#(
    parameter int MC_CYCLES    = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    input  logic                 rdA_en_i,
    input  logic                 rdB_en_i,
    input  logic [REG_IDX_W-1:0] riA_i,
    input  logic [REG_IDX_W-1:0] riB_i,
    input  logic                 wr0_en_i,
    input  logic [REG_IDX_W-1:0] wr0_idx_i,
    input  logic                 wr1_en_i,
    input  logic [REG_IDX_W-1:0] wr1_idx_i,
    input  logic                 multicycle_i,
    input  logic                 wb0_en_i,
    input  logic [REG_IDX_W-1:0] wb0_idx_i,
    input  logic                 wb1_en_i,
    input  logic [REG_IDX_W-1:0] wb1_idx_i,
    input  logic                 branch_taken_i,
    output logic                 stall_o,
    output logic                 flush_o,
    output logic                 issue_o,
    output logic [NUM_REGS-1:0]  pending_o,
    output logic                 busy_o
);

    localparam int CW = $clog2(max_int(MC_CYCLES, FLUSH_CYCLES) + 1);

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                flush_q;
    logic                busy_q;
    logic                haz;
    logic [NUM_REGS-1:0] pending_next;

    cpu_scoreboard u_scoreboard (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .set_en_i       (issue_o),
        .rdA_en_i       (rdA_en_i),
        .riA_i          (riA_i),
        .rdB_en_i       (rdB_en_i),
        .riB_i          (riB_i),
        .wr0_en_i       (wr0_en_i),
        .wr0_idx_i      (wr0_idx_i),
        .wr1_en_i       (wr1_en_i),
        .wr1_idx_i      (wr1_idx_i),
        .wb0_en_i       (wb0_en_i),
        .wb0_idx_i      (wb0_idx_i),
        .wb1_en_i       (wb1_en_i),
        .wb1_idx_i      (wb1_idx_i),
        .haz_o          (haz),
        .pending_o      (pending_o),
        .pending_next_o (pending_next)
    );

    assign stall_o = valid_i & ~flush_q & (haz | (state_q == ST_MULTI));
    assign issue_o = valid_i & ~stall_o & ~flush_q & ~branch_taken_i;

    // Counter holds the cycles remaining in MULTI/FLUSH including the current one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (branch_taken_i) begin
            state_d = ST_FLUSH;
            cnt_d   = CW'(FLUSH_CYCLES);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (issue_o && multicycle_i) begin
                        state_d = ST_MULTI;
                        cnt_d   = CW'(MC_CYCLES - 1);
                    end
                end
                ST_MULTI, ST_FLUSH: begin
                    if (cnt_q <= CW'(1)) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            flush_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flush_q <= (state_d == ST_FLUSH);
            busy_q  <= (|pending_next) | (state_d != ST_IDLE);
        end
    end

    assign flush_o = flush_q;
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_cpu_interlock.sv
// tb/tb_cpu_interlock.sv - self-checking bench for cpu_interlock (directed scenarios plus random vs. model)
module tb_cpu_interlock;

    localparam int MC = 4;
    localparam int FC = 2;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i, rdA_en_i, rdB_en_i, wr0_en_i, wr1_en_i, multicycle_i;
    logic        wb0_en_i, wb1_en_i, branch_taken_i;
    logic [3:0]  riA_i, riB_i, wr0_idx_i, wr1_idx_i, wb0_idx_i, wb1_idx_i;
    logic        stall_o, flush_o, issue_o, busy_o;
    logic [15:0] pending_o;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    cpu_interlock #(.MC_CYCLES(MC), .FLUSH_CYCLES(FC)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i),
        .rdA_en_i(rdA_en_i), .rdB_en_i(rdB_en_i), .riA_i(riA_i), .riB_i(riB_i),
        .wr0_en_i(wr0_en_i), .wr0_idx_i(wr0_idx_i), .wr1_en_i(wr1_en_i), .wr1_idx_i(wr1_idx_i),
        .multicycle_i(multicycle_i),
        .wb0_en_i(wb0_en_i), .wb0_idx_i(wb0_idx_i), .wb1_en_i(wb1_en_i), .wb1_idx_i(wb1_idx_i),
        .branch_taken_i(branch_taken_i),
        .stall_o(stall_o), .flush_o(flush_o), .issue_o(issue_o),
        .pending_o(pending_o), .busy_o(busy_o)
    );

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        valid_i = 0; rdA_en_i = 0; rdB_en_i = 0; wr0_en_i = 0; wr1_en_i = 0;
        multicycle_i = 0; wb0_en_i = 0; wb1_en_i = 0; branch_taken_i = 0;
        riA_i = 0; riB_i = 0; wr0_idx_i = 0; wr1_idx_i = 0; wb0_idx_i = 0; wb1_idx_i = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_i = 1;
        cyc();
        cyc();
        #2;
        checks++; if (pending_o !== 16'h0000) begin errors++; $display("FAIL reset_pending got=%h exp=0000", pending_o); end
        checks++; if (flush_o !== 1'b0) begin errors++; $display("FAIL reset_flush got=%b exp=0", flush_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        checks++; if (stall_o !== 1'b0 || issue_o !== 1'b0) begin errors++; $display("FAIL reset_stall_issue got=%b%b exp=00", stall_o, issue_o); end
        rst_i = 0;
        cyc();
    endtask

    task automatic test_dependency();
        clear_inputs();
        valid_i = 1; wr0_en_i = 1; wr0_idx_i = 3;
        #2;
        checks++; if (issue_o !== 1'b1) begin errors++; $display("FAIL dep_producer_issue got=%b exp=1", issue_o); end
        cyc();
        wr0_en_i = 0; rdA_en_i = 1; riA_i = 3;
        #2;
        checks++; if (pending_o[3] !== 1'b1) begin errors++; $display("FAIL dep_pending_set got=%b exp=1", pending_o[3]); end
        for (int k = 1; k <= 2; k++) begin
            checks++; if (stall_o !== 1'b1 || issue_o !== 1'b0) begin errors++; $display("FAIL dep_stall_%0d got=%b%b exp=10", k, stall_o, issue_o); end
            cyc();
        end
        wb0_en_i = 1; wb0_idx_i = 3;
        #2;
`ifdef MOX125_WB_BYPASS_EN
        checks++; if (issue_o !== 1'b1) begin errors++; $display("FAIL dep_wb_cycle_issue got=%b exp=1", issue_o); end
`else
        checks++; if (stall_o !== 1'b1 || issue_o !== 1'b0) begin errors++; $display("FAIL dep_wb_cycle_stall got=%b%b exp=10", stall_o, issue_o); end
`endif
        cyc();
        wb0_en_i = 0;
        #2;
        checks++; if (pending_o[3] !== 1'b0) begin errors++; $display("FAIL dep_pending_clear got=%b exp=0", pending_o[3]); end
        checks++; if (issue_o !== 1'b1) begin errors++; $display("FAIL dep_after_wb_issue got=%b exp=1", issue_o); end
        clear_inputs();
        cyc();
    endtask

    task automatic test_multicycle();
        clear_inputs();
        valid_i = 1; multicycle_i = 1;
        #2;
        checks++; if (issue_o !== 1'b1) begin errors++; $display("FAIL mc_issue got=%b exp=1", issue_o); end
        cyc();
        multicycle_i = 0;
        for (int k = 1; k < MC; k++) begin
            #2;
            checks++; if (stall_o !== 1'b1 || issue_o !== 1'b0) begin errors++; $display("FAIL mc_stall_%0d got=%b%b exp=10", k, stall_o, issue_o); end
            checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL mc_busy_%0d got=%b exp=1", k, busy_o); end
            cyc();
        end
        #2;
        checks++; if (stall_o !== 1'b0 || issue_o !== 1'b1) begin errors++; $display("FAIL mc_resume got=%b%b exp=01", stall_o, issue_o); end
        clear_inputs();
        cyc();
    endtask

    task automatic test_branch();
        clear_inputs();
        valid_i = 1; branch_taken_i = 1;
        #2;
        checks++; if (issue_o !== 1'b0 || stall_o !== 1'b0) begin errors++; $display("FAIL br_pulse got=%b%b exp=00", stall_o, issue_o); end
        cyc();
        branch_taken_i = 0;
        for (int k = 1; k <= FC; k++) begin
            #2;
            checks++; if (flush_o !== 1'b1 || stall_o !== 1'b0 || issue_o !== 1'b0) begin
                errors++; $display("FAIL br_flush_%0d got=%b%b%b exp=100", k, flush_o, stall_o, issue_o);
            end
            cyc();
        end
        #2;
        checks++; if (flush_o !== 1'b0 || issue_o !== 1'b1) begin errors++; $display("FAIL br_end got=%b%b exp=01", flush_o, issue_o); end
        clear_inputs();
        cyc();
    endtask

    task automatic test_set_clear();
        clear_inputs();
        valid_i = 1; wr0_en_i = 1; wr0_idx_i = 5; wb0_en_i = 1; wb0_idx_i = 5;
        #2;
        checks++; if (issue_o !== 1'b1) begin errors++; $display("FAIL setclr_issue got=%b exp=1", issue_o); end
        cyc();
        clear_inputs();
        #2;
        checks++; if (pending_o !== 16'h0020) begin errors++; $display("FAIL setclr_set_wins got=%h exp=0020", pending_o); end
        wb0_en_i = 1; wb0_idx_i = 5;
        cyc();
        clear_inputs();
        #2;
        checks++; if (pending_o !== 16'h0000) begin errors++; $display("FAIL setclr_cleared got=%h exp=0000", pending_o); end
    endtask

    task automatic test_reset_mid_multi();
        clear_inputs();
        valid_i = 1; multicycle_i = 1; wr0_en_i = 1; wr0_idx_i = 9;
        cyc();
        clear_inputs();
        valid_i = 1;
        cyc();
        #2;
        checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL rstmc_pre_stall got=%b exp=1", stall_o); end
        rst_i = 1;
        cyc();
        rst_i = 0;
        #2;
        checks++; if (pending_o !== 16'h0000) begin errors++; $display("FAIL rstmc_pending got=%h exp=0000", pending_o); end
        checks++; if (stall_o !== 1'b0 || issue_o !== 1'b1) begin errors++; $display("FAIL rstmc_idle got=%b%b exp=01", stall_o, issue_o); end
        checks++; if (busy_o !== 1'b0 || flush_o !== 1'b0) begin errors++; $display("FAIL rstmc_busy_flush got=%b%b exp=00", busy_o, flush_o); end
        clear_inputs();
        cyc();
    endtask

    task automatic test_pop_dual();
        clear_inputs();
        valid_i = 1; wr0_en_i = 1; wr0_idx_i = 1; wr1_en_i = 1; wr1_idx_i = 7;
        cyc();
        clear_inputs();
        #2;
        checks++; if (pending_o !== 16'h0082) begin errors++; $display("FAIL pop_pending got=%h exp=0082", pending_o); end
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL pop_busy got=%b exp=1", busy_o); end
        wb0_en_i = 1; wb0_idx_i = 1; wb1_en_i = 1; wb1_idx_i = 7;
        cyc();
        clear_inputs();
        #2;
        checks++; if (pending_o !== 16'h0000) begin errors++; $display("FAIL pop_retired got=%h exp=0000", pending_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL pop_idle_busy got=%b exp=0", busy_o); end
    endtask

    // Model: set of pending registers plus "cycles of hold left" for multi-cycle and flush.
    task automatic test_random();
        logic [15:0] m_pend, wbm, setm, look;
        int          m_multi, m_flush;
        bit          haz, e_flush, e_stall, e_issue, e_busy;
        clear_inputs();
        rst_i = 1;
        cyc();
        rst_i = 0;
        m_pend = '0; m_multi = 0; m_flush = 0;
        for (int n = 0; n < 400; n++) begin
            valid_i        = ($urandom_range(0, 3) != 0);
            rdA_en_i       = $urandom_range(0, 1);
            rdB_en_i       = $urandom_range(0, 1);
            riA_i          = 4'($urandom_range(0, 3));
            riB_i          = 4'($urandom_range(0, 3));
            wr0_en_i       = $urandom_range(0, 1);
            wr0_idx_i      = 4'($urandom_range(0, 5));
            wr1_en_i       = ($urandom_range(0, 4) == 0);
            wr1_idx_i      = 4'($urandom_range(0, 5));
            multicycle_i   = ($urandom_range(0, 7) == 0);
            wb0_en_i       = $urandom_range(0, 1);
            wb0_idx_i      = 4'($urandom_range(0, 5));
            wb1_en_i       = ($urandom_range(0, 2) == 0);
            wb1_idx_i      = 4'($urandom_range(0, 5));
            branch_taken_i = ($urandom_range(0, 11) == 0);
            #2;
            wbm = (wb0_en_i ? (16'h1 << wb0_idx_i) : 16'h0) | (wb1_en_i ? (16'h1 << wb1_idx_i) : 16'h0);
`ifdef MOX125_WB_BYPASS_EN
            look = m_pend & ~wbm;
`else
            look = m_pend;
`endif
            haz = (rdA_en_i && look[riA_i]) || (rdB_en_i && look[riB_i])
               || (wr0_en_i && look[wr0_idx_i]) || (wr1_en_i && look[wr1_idx_i]);
            e_flush = (m_flush > 0);
            e_stall = valid_i && !e_flush && (haz || m_multi > 0);
            e_issue = valid_i && !e_stall && !e_flush && !branch_taken_i;
            e_busy  = (m_pend != 0) || (m_multi > 0) || (m_flush > 0);
            checks++; if (stall_o !== e_stall) begin errors++; $display("FAIL rnd_stall n=%0d got=%b exp=%b", n, stall_o, e_stall); end
            checks++; if (issue_o !== e_issue) begin errors++; $display("FAIL rnd_issue n=%0d got=%b exp=%b", n, issue_o, e_issue); end
            checks++; if (flush_o !== e_flush) begin errors++; $display("FAIL rnd_flush n=%0d got=%b exp=%b", n, flush_o, e_flush); end
            checks++; if (pending_o !== m_pend) begin errors++; $display("FAIL rnd_pending n=%0d got=%h exp=%h", n, pending_o, m_pend); end
            checks++; if (busy_o !== e_busy) begin errors++; $display("FAIL rnd_busy n=%0d got=%b exp=%b", n, busy_o, e_busy); end
            setm = 16'h0;
            if (e_issue) begin
                if (wr0_en_i) setm[wr0_idx_i] = 1'b1;
                if (wr1_en_i) setm[wr1_idx_i] = 1'b1;
            end
            m_pend = (m_pend & ~wbm) | setm;
            if (branch_taken_i) begin
                m_flush = FC;
                m_multi = 0;
            end else if (m_flush > 0) begin
                m_flush--;
            end else if (m_multi > 0) begin
                m_multi--;
            end else if (e_issue && multicycle_i) begin
                m_multi = MC - 1;
            end
            cyc();
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst_i = 1;
        test_reset();
        test_dependency();
        test_multicycle();
        test_branch();
        test_set_clear();
        test_reset_mid_multi();
        test_pop_dual();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
